// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer that gates CPU commits via CPU_EN_L.
// Breakpoint support is compiled in only when `CPU_RUN_CTRL_BKPT_EN is defined.
module cpu_run_ctrl #(
    parameter int PC_W  = 8,
    parameter int CYC_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [PC_W-1:0]  CMD_ARG,
    input  logic [PC_W-1:0]  PC,
    input  logic             HALT_INSN,
    output logic             CPU_EN_L,
    output logic [1:0]       STATE,
    output logic [1:0]       STOP_CAUSE,
    output logic [CYC_W-1:0] RETIRED
);
    typedef enum logic [1:0] {S_HALTED = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10} state_t;
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_BKPT = 2'b11;

    state_t           state_q;
    logic [PC_W-1:0]  step_cnt_q;
    logic [1:0]       cause_q;
    logic [CYC_W-1:0] retired_q;
    logic             stop;
    logic             commit;
    logic             accept;

`ifdef CPU_RUN_CTRL_BKPT_EN
    logic [PC_W-1:0] bkpt_addr_q;
    logic            bkpt_armed_q;
    logic            resume_q;
    // resume masks the breakpoint so a restart from the breakpoint PC can commit it
    assign stop = HALT_INSN | (bkpt_armed_q & (PC == bkpt_addr_q) & ~resume_q);
`else
    logic unused_pc;
    assign unused_pc = ^PC;
    assign stop = HALT_INSN;
`endif

    assign commit     = (state_q == S_RUN || state_q == S_STEP) && !stop;
    assign accept     = CMD_VALID && CMD_READY;
    assign CPU_EN_L   = ~commit;
    assign CMD_READY  = state_q != S_STEP;
    assign STATE      = state_q;
    assign STOP_CAUSE = cause_q;
    assign RETIRED    = retired_q;

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q    <= S_HALTED;
            step_cnt_q <= '0;
            cause_q    <= 2'b00;
            retired_q  <= '0;
`ifdef CPU_RUN_CTRL_BKPT_EN
            bkpt_addr_q  <= '0;
            bkpt_armed_q <= 1'b0;
            resume_q     <= 1'b0;
`endif
        end else begin
            if (commit)
                retired_q <= retired_q + CYC_W'(1);
`ifdef CPU_RUN_CTRL_BKPT_EN
            if (accept && CMD_OP == OP_BKPT) begin
                bkpt_addr_q  <= CMD_ARG;
                bkpt_armed_q <= 1'b1;
            end
            if (state_q == S_HALTED && accept && (CMD_OP == OP_RUN || CMD_OP == OP_STEP))
                resume_q <= 1'b1;
            else if (commit)
                resume_q <= 1'b0;
`endif
            case (state_q)
                S_HALTED: begin
                    if (accept && CMD_OP == OP_RUN)
                        state_q <= S_RUN;
                    if (accept && CMD_OP == OP_STEP) begin
                        state_q    <= S_STEP;
                        step_cnt_q <= (CMD_ARG == '0) ? PC_W'(1) : CMD_ARG;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_HALTED;
                        cause_q <= HALT_INSN ? 2'b10 : 2'b11;
                    end else if (accept && CMD_OP == OP_HALT) begin
                        state_q <= S_HALTED;
                        cause_q <= 2'b01;
                    end
                end
                S_STEP: begin
                    if (stop) begin
                        state_q    <= S_HALTED;
                        cause_q    <= HALT_INSN ? 2'b10 : 2'b11;
                        step_cnt_q <= '0;
                    end else begin
                        step_cnt_q <= step_cnt_q - PC_W'(1);
                        if (step_cnt_q == PC_W'(1)) begin
                            state_q <= S_HALTED;
                            cause_q <= 2'b01;
                        end
                    end
                end
                default: state_q <= S_HALTED;
            endcase
        end
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer for the 8-bit CPU. It owns the CPU's `EN_L` stall input and decides each cycle whether the CPU commits an instruction. Commands arrive from a debug or host port: halt, free-run, step N instructions, and set breakpoint. The block watches the CPU's `PC` and decoded HALT opcode to stop the core, and counts committed cycles.

## Interface
- `PC_W`, default 8: width of `PC`, `CMD_ARG` and the breakpoint register.
- `CYC_W`, default 16: width of the `RETIRED` counter.

Ports:
- `CLK`  in  1: clock; all state changes on the rising edge.
- `RESET_L`  in  1: reset; one clock, synchronous, active-low.
- `CMD_VALID`  in  1: command present.
- `CMD_READY`  out  1: command accepted on a cycle where `CMD_VALID && CMD_READY`.
- `CMD_OP`  in  2: command code.
  - 00 HALT, 01 RUN, 10 STEP, 11 SET_BKPT.
- `CMD_ARG`  in  PC_W: step count (STEP) or breakpoint address (SET_BKPT).
- `PC`  in  PC_W: current CPU PC.
- `HALT_INSN`  in  1: the instruction at `PC` decodes as HALT.
- `CPU_EN_L`  out  1: 0 = CPU commits this cycle; 1 = CPU holds.
- `STATE`  out  2: 00 HALTED, 01 RUN, 10 STEP.
- `STOP_CAUSE`  out  2: 00 reset, 01 command or step done, 10 HALT instruction, 11 breakpoint.
- `RETIRED`  out  CYC_W: count of cycles with `CPU_EN_L` = 0.

## Operation
- Registers:
  - `state`.
  - `step_cnt` (PC_W bits).
  - `bkpt_addr`.
  - `bkpt_armed`.
  - `resume`: set on any HALTED→RUN/STEP transition; cleared after the first cycle in which `CPU_EN_L` = 0.
  - `STOP_CAUSE`.
  - `RETIRED`.
- Stop condition: `stop = HALT_INSN | (bkpt_armed & PC==bkpt_addr & ~resume)`.
- `CPU_EN_L = ~((state==RUN | state==STEP) & ~stop)`. This is combinational from registered state and inputs.
- `CMD_READY` = 1 in HALTED and RUN, and 0 in STEP.
- HALTED:
  - RUN: go to RUN and set `resume`.
  - STEP: load `step_cnt` = max(`CMD_ARG`, 1), go to STEP and set `resume`.
  - HALT: accepted; no state change.
  - SET_BKPT: load `bkpt_addr`, set `bkpt_armed`.
- RUN:
  - `stop`: go to HALTED; cause 10 if `HALT_INSN`, else 11.
  - Accepted HALT: go to HALTED with cause 01. `CPU_EN_L` is unaffected in the accept cycle, so that instruction still commits.
  - RUN and STEP: accepted no-ops.
  - SET_BKPT: updates the breakpoint and takes effect the next cycle.
- STEP:
  - Each committed cycle decrements `step_cnt`.
  - A commit with `step_cnt`==1 → HALTED with cause 01.
  - `stop` → HALTED with cause 10 or 11; the remaining count is discarded.
- Simultaneous events: `stop` takes priority over an accepted HALT command, so the cause reported is 10 or 11.
- The HALT instruction is terminal. Resuming with `HALT_INSN` high returns to HALTED next edge with 0 commits and cause 10.
- `RETIRED` increments on every cycle with `CPU_EN_L` = 0 and wraps modulo 2^CYC_W.

## Timing
- Reset (`RESET_L`=0 at an edge):
  - `state`=HALTED, `CPU_EN_L`=1, `CMD_READY`=1, `STOP_CAUSE`=00.
  - `RETIRED`=0, `step_cnt`=0, `bkpt_addr`=0, `bkpt_armed`=0, `resume`=0.
- Reset overrides any command or stop in the same cycle, including mid-STEP.
- Command latency: a RUN or STEP accepted at edge k gives `CPU_EN_L`=0 from cycle k+1, unless `stop` is true.
- On a stop detected in cycle k:
  - `CPU_EN_L`=1 in cycle k.
  - `STATE`=HALTED and `STOP_CAUSE` updated from edge k+1.
- STEP N with no stop: exactly N cycles with `CPU_EN_L`=0, then HALTED.

## Configuration
- `CPU_RUN_CTRL_BKPT_EN` defined:
  - Breakpoint register, comparator and `resume` qualification are compiled in, as described above.
- Undefined:
  - No breakpoint logic; the stop term is `HALT_INSN` only.
  - SET_BKPT is accepted and ignored.
  - `STOP_CAUSE` is never 11.

## Test plan
- Reset: hold `RESET_L`=0 for 2 cycles → `STATE`=00, `CPU_EN_L`=1, `CMD_READY`=1, `RETIRED`=0, `STOP_CAUSE`=00.
- STEP with `CMD_ARG`=3 from HALTED, PC advancing 0,2,4,6:
  - `CPU_EN_L`=0 for exactly 3 cycles; `CMD_READY`=0 during that window.
  - Then `STATE`=00, `STOP_CAUSE`=01, `RETIRED`=3.
  - A STEP with `CMD_ARG`=0 gives 1 commit.
- Breakpoint: SET_BKPT 0x06, then RUN from PC=0:
  - Commits at 0,2,4; `CPU_EN_L`=1 at PC=6; `STOP_CAUSE`=11.
  - A second RUN at PC=6 commits PC 6 and continues.
- HALT instruction: RUN with `HALT_INSN`=1 at PC=0x0A → `CPU_EN_L`=1 that cycle, HALTED, cause 10.
  - Re-RUN → 0 commits, cause 10 again.
- Priority and reset:
  - HALT command issued in the same cycle as a breakpoint match → cause 11.
  - `RESET_L`=0 mid-STEP (count 5, 2 done) → HALTED next edge and `RETIRED`=0.
- Wrap: with `CYC_W`=4, 17 committed cycles → `RETIRED`=1.
- With the macro undefined: SET_BKPT 0x04, then RUN → no stop at PC=4.
